// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_share_arbiter_if
// Brief   : Request/response and ALU-drive bundle for alu_share_arbiter.
// Rev     : 1.0
// ============================================================================
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_src0;
    logic [NUM_REQ*32-1:0] req_src1;
    logic [NUM_REQ*5-1:0]  req_op;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready;
    logic [31:0]           resp_res;
    logic [31:0]           alu_src0;
    logic [31:0]           alu_src1;
    logic [4:0]            alu_op;
    logic [31:0]           alu_res;

    modport master (
        output req_valid, req_src0, req_src1, req_op, resp_ready, alu_res,
        input  req_ready, resp_valid, resp_res, alu_src0, alu_src1, alu_op
    );

    modport slave (
        input  req_valid, req_src0, req_src1, req_op, resp_ready, alu_res,
        output req_ready, resp_valid, resp_res, alu_src0, alu_src1, alu_op
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : alu_share_arbiter
// Brief   : Round-robin time-sharing of one combinational ALU, 1-cycle result.
// Rev     : 1.0
// ============================================================================
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [0:0] {
        ST_FREE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_last;
    logic [31:0]      r_res;
    logic [IDX_W-1:0] w_winner;
    logic             w_any_req;
    logic             w_owner_ready;
    logic             w_can_issue;
    logic             w_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FREE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        int idx;
        idx           = 0;
        w_winner      = '0;
        w_any_req     = 1'b0;
        w_owner_ready = 1'b0;
        w_state_nxt   = r_state;
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        bus.alu_src0   = 32'd0;
        bus.alu_src1   = 32'd0;
        bus.alu_op     = 5'b00000;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_owner_ready = bus.resp_ready[i];
            end
        end

        // Scan from farthest to nearest so the nearest valid after r_last wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(r_last) + k) % NUM_REQ;
            if (bus.req_valid[idx]) begin
                w_any_req = 1'b1;
                w_winner  = IDX_W'(idx);
            end
        end

        w_can_issue = (r_state == ST_FREE) || w_owner_ready;
        w_grant     = w_can_issue && w_any_req && !rst;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant && (w_winner == IDX_W'(i))) begin
                bus.req_ready[i] = 1'b1;
                bus.alu_src0     = bus.req_src0[32*i +: 32];
                bus.alu_src1     = bus.req_src1[32*i +: 32];
                bus.alu_op       = bus.req_op[5*i +: 5];
            end
            if ((r_state == ST_HELD) && (r_owner == IDX_W'(i))) begin
                bus.resp_valid[i] = 1'b1;
            end
        end

        if (w_grant) begin
            w_state_nxt = ST_HELD;
        end else if ((r_state == ST_HELD) && w_owner_ready) begin
            w_state_nxt = ST_FREE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res   <= 32'd0;
            r_owner <= '0;
            r_last  <= IDX_W'(NUM_REQ - 1);
        end else if (w_grant) begin
            r_res   <= bus.alu_res;
            r_owner <= w_winner;
            r_last  <= w_winner;
        end
    end

    assign bus.resp_res = r_res;

endmodule
`default_nettype wire
